// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI burst memory slave.
// Burst encodings, response codes and write FSM states.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Next word index for FIXED/INCR/WRAP bursts plus range checks.
// Purely combinational; the caller registers the result.
module axi_mem_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int IDX_WIDTH = 30,
    parameter int MEM_DEPTH = 256
) (
    input  logic [IDX_WIDTH-1:0] idx,
    input  logic [7:0]           len,
    input  logic [1:0]           burst,
    output logic [IDX_WIDTH-1:0] next_idx,
    output logic                 oob,
    output logic                 bad_burst
);
    localparam int MW = $clog2(MEM_DEPTH);

    burst_t               btype;
    logic [IDX_WIDTH-1:0] mask;
    logic [IDX_WIDTH-1:0] inc;
    logic                 wrap_len_ok;

    assign btype       = burst_t'(burst);
    assign mask        = IDX_WIDTH'(len);
    assign inc         = idx + IDX_WIDTH'(1);
    assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) ||
                         (len == 8'd7) || (len == 8'd15);
    assign oob         = |idx[IDX_WIDTH-1:MW];

    // WRAP keeps the aligned window bits and lets only the low bits roll over
    always_comb begin
        next_idx  = idx;
        bad_burst = 1'b0;
        unique case (btype)
            BURST_FIXED: next_idx = idx;
            BURST_INCR:  next_idx = inc;
            BURST_WRAP: begin
                next_idx  = (idx & ~mask) | (inc & mask);
                bad_burst = !wrap_len_ok;
            end
            BURST_RSVD:  bad_burst = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI write-burst memory slave with a registered backdoor read port.
// Define AXI_MEM_STALL_EN to drop wready for one cycle every STALL_PERIOD beats.
module axi_burst_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int MEM_DEPTH    = 256,
    parameter int STALL_PERIOD = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ID_WIDTH-1:0]          awid,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [7:0]                   awlen,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [ID_WIDTH-1:0]          bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IW     = ADDR_WIDTH - OFFS;
    localparam int MW     = $clog2(MEM_DEPTH);
`ifdef AXI_MEM_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif
    localparam logic [7:0] SP_M1 = 8'(STALL_PERIOD - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wr_state_t           state;
    logic [ID_WIDTH-1:0] id_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [7:0]          stall_cnt;
    logic [1:0]          burst_q;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       next_idx;
    logic                err_q;
    logic                oob;
    logic                bad_burst;
    logic                beat;
    logic                last;
    logic                beat_err;
    logic                wr_en;
    logic                unused_addr;

    assign unused_addr = ^awaddr;

    axi_mem_addr_gen #(
        .IDX_WIDTH (IW),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_addr_gen (
        .idx       (idx_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_idx  (next_idx),
        .oob       (oob),
        .bad_burst (bad_burst)
    );

    assign beat     = wvalid && wready;
    assign last     = (cnt_q == len_q);
    assign beat_err = bad_burst || oob || (wlast != last);
    assign wr_en    = beat && !bad_burst && !oob;

    // Storage has no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[idx_q[MW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dbg_rdata <= '0;
        else        dbg_rdata <= mem[dbg_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= W_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            bid       <= '0;
            id_q      <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        id_q      <= awid;
                        len_q     <= awlen;
                        burst_q   <= awburst;
                        idx_q     <= awaddr[ADDR_WIDTH-1:OFFS];
                        cnt_q     <= '0;
                        stall_cnt <= '0;
                        err_q     <= 1'b0;
                        awready   <= 1'b0;
                        wready    <= 1'b1;
                        state     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (beat) begin
                        cnt_q <= cnt_q + 8'd1;
                        idx_q <= next_idx;
                        if (beat_err) err_q <= 1'b1;
                        if (last) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state  <= W_RESP;
                        end else if (STALL_EN && stall_cnt == SP_M1) begin
                            wready    <= 1'b0;
                            stall_cnt <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                    end else if (!wready) begin
                        wready <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        bresp   <= RESP_OKAY;
                        err_q   <= 1'b0;
                        awready <= 1'b1;
                        state   <= W_IDLE;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomised scoreboard bench for axi_burst_mem_slave.
// Reference memory is updated per burst from the address/burst rules.
`timescale 1ns/1ps
module tb_axi_burst_mem_slave;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int IDW   = 4;
    localparam int DEPTH = 256;
`ifdef AXI_MEM_STALL_EN
    localparam int SP       = 2;
    localparam bit STALL_ON = 1'b1;
`else
    localparam int SP       = 4;
    localparam bit STALL_ON = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [IDW-1:0] awid;
    logic [AW-1:0]  awaddr;
    logic [7:0]     awlen;
    logic [1:0]     awburst;
    logic           awvalid;
    logic           awready;
    logic [DW-1:0]  wdata;
    logic [3:0]     wstrb;
    logic           wlast;
    logic           wvalid;
    logic           wready;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [7:0]     dbg_addr;
    logic [DW-1:0]  dbg_rdata;

    axi_burst_mem_slave #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .ID_WIDTH     (IDW),
        .MEM_DEPTH    (DEPTH),
        .STALL_PERIOD (SP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model_mem [DEPTH];
    logic [5:0]  exp_q [$];
    logic [31:0] bd [$];
    logic [3:0]  bs [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic abort(input string nm);
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    endtask

    // Reference model: walk the beats of a burst and apply them to model_mem
    function automatic bit model_burst(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [1:0] bt, input int wl_beat);
        int unsigned start, n, idx, base;
        bit err;
        start = addr / 4;
        n     = int'(len) + 1;
        err   = (wl_beat != int'(len));
        if (bt == 2'b11) return 1'b1;
        if (bt == 2'b10 && !(n == 2 || n == 4 || n == 8 || n == 16)) return 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            if (bt == 2'b00)      idx = start;
            else if (bt == 2'b01) idx = start + i;
            else begin
                base = (start / n) * n;
                idx  = base + (start - base + i) % n;
            end
            if (idx >= DEPTH) err = 1'b1;
            else begin
                for (int b = 0; b < 4; b++)
                    if (bs[i][b]) model_mem[idx][b*8 +: 8] = bd[i][b*8 +: 8];
            end
        end
        return err;
    endfunction

    task automatic load_rand(input int n, input bit full);
        bd.delete();
        bs.delete();
        for (int i = 0; i < n; i++) begin
            bd.push_back($urandom);
            bs.push_back(full ? 4'hF : 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] bt);
        int t;
        awid = id; awaddr = addr; awlen = len; awburst = bt; awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!awready && t < 50) begin t++; @(negedge clk); end
        if (!awready) abort("aw_handshake");
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input int i, input bit lst, inout int stalls);
        int t;
        wvalid = 1'b1; wdata = bd[i]; wstrb = bs[i]; wlast = lst;
        t = 0;
        @(negedge clk);
        while (!wready && t < 50) begin t++; stalls++; @(negedge clk); end
        if (!wready) abort("w_handshake");
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] bt, input int wl_beat, input int bdelay, input string nm);
        bit err;
        int stalls, t;
        err = model_burst(addr, len, bt, wl_beat);
        exp_q.push_back({id, err ? 2'b10 : 2'b00});
        send_aw(id, addr, len, bt);
        stalls = 0;
        for (int i = 0; i <= int'(len); i++) send_w(i, i == wl_beat, stalls);
        check({nm, " stalls"}, stalls, STALL_ON ? int'(len) / SP : 0);
        t = 0;
        @(negedge clk);
        while (!bvalid && t < 50) begin t++; @(negedge clk); end
        if (!bvalid) abort({nm, " bvalid"});
        for (int k = 0; k < bdelay; k++) begin
            check({nm, " bvalid_hold"}, bvalid, 1);
            check({nm, " awready_low"}, awready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic check_mem(input int idx);
        dbg_addr = 8'(idx);
        @(posedge clk); #1;
        check($sformatf("mem[%0d]", idx), dbg_rdata, model_mem[idx]);
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, " awready"}, awready, 0);
        check({nm, " wready"}, wready, 0);
        check({nm, " bvalid"}, bvalid, 0);
        check({nm, " bresp"}, bresp, 0);
        check({nm, " bid"}, bid, 0);
        check({nm, " dbg_rdata"}, dbg_rdata, 0);
    endtask

    // Scoreboard monitor: compares every B handshake with the next expected response
    always @(negedge clk) begin
        logic [5:0] e;
        if (rst_n && bvalid && bready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected: got %0h expected none", {bid, bresp});
            end else begin
                e = exp_q.pop_front();
                check("b_id_resp", {bid, bresp}, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int stalls, len, r, wl;
        logic [1:0] bt;
        rst_n = 1'b0; awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        load_rand(256, 1'b1);
        do_burst(4'h1, 32'h0, 8'd255, 2'b01, 255, 1, "init");

        bd = '{32'd100, 32'd200, 32'd300, 32'd400};
        bs = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_burst(4'h5, 32'h10, 8'd3, 2'b01, 3, 0, "incr");
        for (int i = 4; i < 8; i++) check_mem(i);
        check("incr mem[6] const", model_mem[6], 32'd300);

        bd = '{32'd1, 32'd2, 32'd3};
        bs = '{4'hF, 4'hF, 4'hF};
        do_burst(4'h6, 32'h8, 8'd2, 2'b00, 2, 0, "fixed");
        check_mem(2);
        check("fixed mem[2] const", model_mem[2], 32'd3);

        bd = '{32'h61, 32'h71, 32'h41, 32'h51};
        bs = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_burst(4'h7, 32'h18, 8'd3, 2'b10, 3, 0, "wrap");
        for (int i = 4; i < 8; i++) check_mem(i);
        check("wrap mem[4] const", model_mem[4], 32'h41);
        load_rand(3, 1'b1);
        do_burst(4'h8, 32'h18, 8'd2, 2'b10, 2, 0, "wrap_badlen");

        bd = '{32'hAAAAAAAA}; bs = '{4'hF};
        do_burst(4'h9, 32'h24, 8'd0, 2'b01, 0, 0, "prefill");
        bd = '{32'h12345678}; bs = '{4'h3};
        do_burst(4'hA, 32'h24, 8'd0, 2'b01, 0, 0, "strobe");
        check_mem(9);
        check("strobe mem[9] const", model_mem[9], 32'hAAAA5678);
        load_rand(4, 1'b1);
        do_burst(4'hB, 32'h30, 8'd3, 2'b01, 1, 0, "early_wlast");
        load_rand(3, 1'b1);
        do_burst(4'hC, 32'h40, 8'd2, 2'b01, -1, 0, "missing_wlast");

        load_rand(4, 1'b1);
        do_burst(4'hD, 32'd254 * 4, 8'd3, 2'b01, 3, 0, "oob_incr");
        check_mem(254);
        check_mem(255);
        load_rand(2, 1'b1);
        do_burst(4'hE, 32'h8000_0000, 8'd1, 2'b00, 1, 0, "oob_high");
        load_rand(2, 1'b1);
        do_burst(4'hF, 32'h60, 8'd1, 2'b11, 1, 0, "reserved");
        check_mem(24);

        load_rand(8, 1'b1);
        do_burst(4'h2, 32'h80, 8'd7, 2'b01, 7, 5, "stall_hold");

        load_rand(4, 1'b1);
        send_aw(4'h3, 32'h40, 8'd3, 2'b01);
        stalls = 0;
        for (int i = 0; i < 2; i++) begin
            send_w(i, 1'b0, stalls);
            model_mem[16 + i] = bd[i];
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_rand(4, 1'b1);
        do_burst(4'h4, 32'h50, 8'd3, 2'b01, 3, 0, "after_reset");
        check_mem(16);
        check_mem(17);
        check_mem(20);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            bt = (r < 3) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            if (bt == 2'b10) begin
                r = $urandom_range(0, 4);
                len = (r == 4) ? 2 : (1 << (r + 1)) - 1;
            end else begin
                len = $urandom_range(0, 15);
            end
            wl = len;
            if ($urandom_range(0, 7) == 0) wl = int'($urandom_range(0, len + 1)) - 1;
            load_rand(len + 1, 1'b0);
            do_burst(4'($urandom), 32'($urandom_range(0, 270 * 4)), 8'(len), bt,
                     wl, $urandom_range(0, 3), $sformatf("rand%0d", n));
        end

        for (int i = 0; i < DEPTH; i++) check_mem(i);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
